// File: rtl/axi4_ram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi4_ram_responder
// Purpose  : AXI4 slave (64-bit data, 1-bit ID, INCR only) backed by an
//            internal synchronous RAM. Optional macro AXI4_RAM_OOR_ERR_EN
//            flags beats outside the RAM window with SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_ram_responder #(
   parameter int unsigned           MEM_WORDS  = 65536,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  awid,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic [7:0]            awlen,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [63:0]           wdata,
   input  logic [7:0]            wstrb,
   input  logic                  wlast,
   input  logic                  wvalid,
   output logic                  wready,
   output logic                  bid,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   input  logic                  arid,
   input  logic [ADDR_WIDTH-1:0] araddr,
   input  logic [7:0]            arlen,
   input  logic                  arvalid,
   output logic                  arready,
   output logic                  rid,
   output logic [63:0]           rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic                  rvalid,
   input  logic                  rready
);

   localparam int unsigned      IW        = $clog2(MEM_WORDS);
   localparam int unsigned      WA_W      = ADDR_WIDTH - 2;
   localparam logic [WA_W-1:0]  BASE_WORD = WA_W'(BASE_ADDR >> 3);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_e;

   // Word addresses carry one extra MSB so bursts past the top of the
   // address space stay distinguishable from low addresses.
   function automatic logic [IW-1:0] word_idx(input logic [WA_W-1:0] wa);
      return IW'(wa - BASE_WORD);
   endfunction

`ifdef AXI4_RAM_OOR_ERR_EN
   function automatic logic out_of_range(input logic [WA_W-1:0] wa);
      logic [WA_W:0] diff;
      diff = {1'b0, wa} - {1'b0, BASE_WORD};
      return diff[WA_W] || ((diff[WA_W-1:0] >> IW) != '0);
   endfunction
`endif

   logic [63:0] mem [MEM_WORDS];

   wstate_e         wstate_q, wstate_d;
   logic            awready_q, awready_d, wready_q, wready_d;
   logic            bvalid_q, bvalid_d, bid_q, bid_d, werr_q, werr_d;
   logic [1:0]      bresp_q, bresp_d;
   logic [WA_W-1:0] wwa_q, wwa_d;
   logic [7:0]      wlen_q, wlen_d, wcnt_q, wcnt_d;
   logic [IW-1:0]   w_wr_idx;
   logic            w_wr_oor, w_wbeat_last, w_wbeat_err, w_mem_we;

   rstate_e         rstate_q, rstate_d;
   logic            arready_q, arready_d, rvalid_q, rvalid_d;
   logic            rid_q, rid_d, rlast_q, rlast_d;
   logic [1:0]      rresp_q, rresp_d;
   logic [WA_W-1:0] rwa_q, rwa_d, w_rd_wa;
   logic [7:0]      rlen_q, rlen_d, rcnt_q, rcnt_d;
   logic [63:0]     rdata_q;
   logic [IW-1:0]   w_rd_idx;
   logic            w_rd_oor, w_rd_en;

   assign w_wr_idx     = word_idx(wwa_q);
   assign w_wbeat_last = (wcnt_q == wlen_q);
   assign w_wbeat_err  = (wlast != w_wbeat_last) || w_wr_oor;
   assign w_rd_wa      = (rstate_q == R_DATA) ? rwa_q + 1'b1 : rwa_q;
   assign w_rd_idx     = word_idx(w_rd_wa);
`ifdef AXI4_RAM_OOR_ERR_EN
   assign w_wr_oor = out_of_range(wwa_q);
   assign w_rd_oor = out_of_range(w_rd_wa);
`else
   assign w_wr_oor = 1'b0;
   assign w_rd_oor = 1'b0;
`endif

   always_comb begin
      wstate_d  = wstate_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bid_d     = bid_q;
      bresp_d   = bresp_q;
      werr_d    = werr_q;
      wwa_d     = wwa_q;
      wlen_d    = wlen_q;
      wcnt_d    = wcnt_q;
      w_mem_we  = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            awready_d = 1'b1;
            if (awvalid && awready_q) begin
               wwa_d     = WA_W'(awaddr >> 3);
               wlen_d    = awlen;
               wcnt_d    = '0;
               werr_d    = 1'b0;
               bid_d     = awid;
               awready_d = 1'b0;
               wready_d  = 1'b1;
               wstate_d  = W_DATA;
            end
         end
         W_DATA: begin
            if (wvalid && wready_q) begin
               w_mem_we = !w_wr_oor;
               werr_d   = werr_q || w_wbeat_err;
               wwa_d    = wwa_q + 1'b1;
               wcnt_d   = wcnt_q + 8'd1;
               // Burst length comes from awlen; wlast only feeds the error flag.
               if (w_wbeat_last) begin
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  bresp_d  = (werr_q || w_wbeat_err) ? 2'b10 : 2'b00;
                  wstate_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (bready) begin
               bvalid_d  = 1'b0;
               bresp_d   = 2'b00;
               awready_d = 1'b1;
               wstate_d  = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   always_comb begin
      rstate_d  = rstate_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rid_d     = rid_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      rwa_d     = rwa_q;
      rlen_d    = rlen_q;
      rcnt_d    = rcnt_q;
      w_rd_en   = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (arvalid && arready_q) begin
               rwa_d     = WA_W'(araddr >> 3);
               rlen_d    = arlen;
               rcnt_d    = '0;
               rid_d     = arid;
               arready_d = 1'b0;
               rstate_d  = R_FETCH;
            end
         end
         R_FETCH: begin
            w_rd_en  = 1'b1;
            rvalid_d = 1'b1;
            rlast_d  = (rlen_q == 8'd0);
            rresp_d  = w_rd_oor ? 2'b10 : 2'b00;
            rstate_d = R_DATA;
         end
         R_DATA: begin
            if (rready && rvalid_q) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  rresp_d   = 2'b00;
                  arready_d = 1'b1;
                  rstate_d  = R_IDLE;
               end else begin
                  // Prefetch the following word on acceptance to avoid bubbles.
                  w_rd_en = 1'b1;
                  rwa_d   = w_rd_wa;
                  rcnt_d  = rcnt_q + 8'd1;
                  rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                  rresp_d = w_rd_oor ? 2'b10 : 2'b00;
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= 1'b0;
         bresp_q   <= 2'b00;
         werr_q    <= 1'b0;
         wwa_q     <= '0;
         wlen_q    <= '0;
         wcnt_q    <= '0;
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rid_q     <= 1'b0;
         rresp_q   <= 2'b00;
         rlast_q   <= 1'b0;
         rwa_q     <= '0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
         rdata_q   <= '0;
      end else begin
         wstate_q  <= wstate_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
         werr_q    <= werr_d;
         wwa_q     <= wwa_d;
         wlen_q    <= wlen_d;
         wcnt_q    <= wcnt_d;
         rstate_q  <= rstate_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rid_q     <= rid_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
         rwa_q     <= rwa_d;
         rlen_q    <= rlen_d;
         rcnt_q    <= rcnt_d;
         if (w_rd_en)
            rdata_q <= w_rd_oor ? '0 : mem[w_rd_idx];
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_mem_we) begin
         for (int b = 0; b < 8; b++) begin
            if (wstrb[b])
               mem[w_wr_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bid     = bid_q;
   assign bresp   = bresp_q;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rid     = rid_q;
   assign rresp   = rresp_q;
   assign rlast   = rlast_q;
   assign rdata   = rdata_q;

endmodule
`default_nettype wire

// File: doc/axi4_ram_responder.md
Name: axi4_ram_responder

Overview:
- AXI4 memory responder (slave), 64-bit data, 32-bit address, 1-bit ID, backed by an internal synchronous RAM array.
- Serves the frame buffer's write and read memory ports in simulation and on small FPGA configs, where it replaces external DDR.
- Independent write path (AW/W/B) and read path (AR/R); each path handles one burst at a time.
- INCR bursts only, full-width beats only.

Parameters:
BASE_ADDR, 0, byte address mapped to RAM word 0
MEM_WORDS, 65536, RAM depth in 64-bit words; power of two, >= 2
ADDR_WIDTH, 32, AXI address width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
awid  in  1  write burst ID
awaddr  in  ADDR_WIDTH  write start byte address
awlen  in  8  write beats minus 1
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  64  write data
wstrb  in  8  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  1  echoed awid
bresp  out  2  write response
bvalid  out  1  B valid
bready  in  1  B ready
arid  in  1  read burst ID
araddr  in  ADDR_WIDTH  read start byte address
arlen  in  8  read beats minus 1
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  1  echoed arid
rdata  out  64  read data
rresp  out  2  read response
rlast  out  1  last read beat
rvalid  out  1  R valid
rready  in  1  R ready

Behaviour:
- Interface decided: single clock clk_i; reset rst_n_i is asynchronous, active-low.
- Reset values: all outputs 0, including awready and arready; both FSMs go to IDLE. RAM contents are not reset.
- awready and arready are registered. They rise 1 cycle after reset release.
- Word index = (addr - BASE_ADDR) >> 3, taken modulo MEM_WORDS. addr[2:0] is ignored. Size is always 8 bytes. awburst and arburst are treated as INCR. 4KB-boundary crossing is not checked.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid, latch id, index and len, clear the beat counter, drop awready, go to W_DATA.
  - W_DATA: wready=1. Each wvalid&&wready beat writes the bytes enabled by wstrb at index, then index+1 (wraps modulo MEM_WORDS) and counter+1.
  - The beat where counter==len ends the burst. Go to W_RESP and drop wready.
  - wlast mismatch (asserted early, or absent on the final beat) sets a sticky error. Exactly len+1 beats are still consumed.
  - W_RESP: bvalid=1, bid=latched id, bresp=2'b10 (SLVERR) if the sticky error is set, else 2'b00. Hold until bready, then return to W_IDLE with awready=1 on the next cycle.
- Read FSM: R_IDLE -> R_FETCH -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On handshake, latch id, index and len; go to R_FETCH.
  - R_FETCH: 1-cycle RAM read.
  - R_DATA: rvalid=1, rid=id, rresp=00, rlast=1 when counter==len.
  - First rvalid appears 2 cycles after the AR handshake.
  - rdata, rlast and rid stay stable while rvalid&&!rready.
  - On each accepted beat, the next word is prefetched so that rvalid stays asserted back-to-back (no bubbles when rready is held high).
  - After the rlast beat is accepted, go to R_IDLE.
- Write and read paths run concurrently. A read of a word written in the same cycle returns the pre-write data.
- Asserting rst_n_i mid-burst immediately aborts both FSMs and clears all outputs. The burst in flight is lost; RAM keeps any beats already written.

Optional Feature:
Macro AXI4_RAM_OOR_ERR_EN.
- Defined:
  - A beat whose byte offset (addr - BASE_ADDR, computed per beat) is negative or >= MEM_WORDS*8 is out of range.
  - Out-of-range write beats are discarded and set the sticky error, so bresp=SLVERR.
  - Out-of-range read beats return rdata=0, rresp=2'b10.
- Undefined: index wraps modulo MEM_WORDS and every response is OKAY, except the wlast-mismatch case.

Test Plan:
- Reset release, then AW awaddr=0x40, awlen=3, four W beats 0x11..0x44, wstrb=0xFF -> one B with bresp=00, bid=awid. AR 0x40 len 3 -> rdata 0x11,0x22,0x33,0x44; rlast only on beat 4; first rvalid 2 cycles after AR.
- Partial write wstrb=0x0F, data 0xFFFFFFFF_FFFFFFFF, over word 0 holding 0x0123456789ABCDEF -> readback 0x01234567FFFFFFFF.
- Read awlen=255 burst with rready toggled 1-0-1 randomly -> 256 beats, no duplication or skip, data stable while stalled, rlast on beat 256.
- Write awlen=1 with wlast on beat 1 -> 2 beats consumed, bresp=10.
- Write at word MEM_WORDS-1, len 1 -> second beat lands at word 0 (feature off). With AXI4_RAM_OOR_ERR_EN -> second beat dropped, bresp=10.
- Assert rst_n_i mid-read burst -> rvalid=0 and arready=0 asynchronously; a new AR is accepted 1 cycle after release.
